sevenseg_mux: RTL and testbench

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

---
 rtl/sevenseg_pkg.sv | 41 ++++
 rtl/sevenseg_decode.sv | 16 +
 rtl/sevenseg_mux.sv | 189 ++++++++++++++++++
 tb/tb_sevenseg_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared constants for the multiplexed seven-segment driver: true-high segment
// codes for the decimal digits, the blank pattern, and the code-to-segment
// conversion function used by sevenseg_decode.
// Segment bit order is {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
package sevenseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Codes 10..15 are not decimal digits and show nothing.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
      logic [6:0] seg_v;
      case (code)
         4'd0:    seg_v = SEG_0;
         4'd1:    seg_v = SEG_1;
         4'd2:    seg_v = SEG_2;
         4'd3:    seg_v = SEG_3;
         4'd4:    seg_v = SEG_4;
         4'd5:    seg_v = SEG_5;
         4'd6:    seg_v = SEG_6;
         4'd7:    seg_v = SEG_7;
         4'd8:    seg_v = SEG_8;
         4'd9:    seg_v = SEG_9;
         default: seg_v = SEG_BLANK;
      endcase
      return seg_v;
   endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_decode
// Purely combinational BCD to seven-segment decoder (true-high segments).
//   code_i : 4-bit digit code
//   seg_o  : segments {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   assign seg_o = bcd_to_seg(code_i);

endmodule

// File: rtl/sevenseg_mux.sv
// -----------------------------------------------------------------------------
// sevenseg_mux
// Time-multiplexed driver for a NUM_DIGITS seven-segment display. A prescaler
// holds each digit for REFRESH_DIV cycles; new values are staged in a shadow
// register and only reach the display register at a frame wrap, so a frame is
// never shown half old / half new.
//   clk, rst     : clock, synchronous active-high reset
//   load         : one-cycle strobe capturing bcd_in / dp_in
//   bcd_in       : digit codes, nibble 0 = least significant digit
//   dp_in        : decimal-point enables, one per digit
//   blank_lz     : live leading-zero suppression enable
//   seg, dp, an  : registered segment / decimal point / digit enables
//   frame_done   : registered one-cycle pulse per frame
// -----------------------------------------------------------------------------
module sevenseg_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   // Off levels; XOR-ing a true-high value with these applies the polarity.
   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] AN_RST  = AN_OFF ^ NUM_DIGITS'(1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic [BCD_W-1:0]      shadow_bcd_q, shadow_bcd_d;
   logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic [BCD_W-1:0]      disp_bcd_q, disp_bcd_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic                  wrap_q;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_done_q;

   logic                  tc_s;
   logic                  wrap_s;
   logic [3:0]            digit_s [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] zero_run_s;
   logic [3:0]            sel_code_s;
   logic [6:0]            dec_seg_s;
   logic                  lz_blank_s;
   logic [6:0]            seg_lit_s;
   logic                  dp_lit_s;
   logic [NUM_DIGITS-1:0] an_hot_s;

   assign tc_s   = (cnt_q == CNT_MAX);
   assign wrap_s = tc_s && (idx_q == IDX_MAX);

   // zero_run_s[k] is set when digits k..NUM_DIGITS-1 are all zero.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
      assign digit_s[g]    = disp_bcd_q[4*g +: 4];
      assign zero_run_s[g] = (disp_bcd_q[BCD_W-1:4*g] == '0);
   end

   assign sel_code_s = digit_s[idx_q];

   sevenseg_decode u_decode (
      .code_i (sel_code_s),
      .seg_o  (dec_seg_s)
   );

   // Digit 0 is never suppressed, so the index must be non-zero to blank.
   assign lz_blank_s = blank_lz && (idx_q != '0) && zero_run_s[idx_q];

   // Scan counters and tear-free shadow/display update
   always_comb begin
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pend_d       = pend_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      disp_bcd_d   = disp_bcd_q;
      disp_dp_d    = disp_dp_q;

      if (tc_s) begin
         cnt_d = '0;
         if (wrap_s) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // The display register only ever changes on the frame wrap; a load on
      // that very cycle bypasses the shadow so it is not delayed a frame.
      if (wrap_s) begin
         pend_d = 1'b0;
         if (load) begin
            disp_bcd_d = bcd_in;
            disp_dp_d  = dp_in;
         end else if (pend_q) begin
            disp_bcd_d = shadow_bcd_q;
            disp_dp_d  = shadow_dp_q;
         end else begin
            disp_bcd_d = disp_bcd_q;
            disp_dp_d  = disp_dp_q;
         end
      end else if (load) begin
         shadow_bcd_d = bcd_in;
         shadow_dp_d  = dp_in;
         pend_d       = 1'b1;
      end else begin
         pend_d = pend_q;
      end
   end

   // Output pattern for the current index, polarity applied last
   always_comb begin
      an_hot_s        = '0;
      an_hot_s[idx_q] = 1'b1;
      if (lz_blank_s) begin
         seg_lit_s = SEG_BLANK;
         dp_lit_s  = 1'b0;
      end else begin
         seg_lit_s = dec_seg_s;
         dp_lit_s  = disp_dp_q[idx_q];
      end
      seg_d = seg_lit_s ^ SEG_OFF;
      dp_d  = dp_lit_s ^ DP_OFF;
      an_d  = an_hot_s ^ AN_OFF;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         shadow_bcd_q <= {BCD_W{1'b1}};
         shadow_dp_q  <= '0;
         disp_bcd_q   <= {BCD_W{1'b1}};
         disp_dp_q    <= '0;
         wrap_q       <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_RST;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_bcd_q   <= disp_bcd_d;
         disp_dp_q    <= disp_dp_d;
         wrap_q       <= wrap_s;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         // Delayed one extra stage so the pulse lines up with the first
         // output cycle of digit 0 in the new frame.
         frame_done_q <= wrap_q;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_mux
// Self-checking bench for sevenseg_mux with NUM_DIGITS=4, REFRESH_DIV=4,
// active-low segments and anodes. A frame is 16 cycles; each digit is held
// for 4 of them. The reference model tracks the number of clock edges since
// reset and derives the scan position arithmetically from it.
// -----------------------------------------------------------------------------
module tb_sevenseg_mux;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   sevenseg_mux #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
   };

   int vec_cnt = 0;
   int mis_cnt = 0;

   // Reference model state
   logic [15:0] m_disp, m_shad;
   logic [3:0]  m_dp, m_sdp;
   logic        m_pend;
   int          k;       // index of the next non-reset edge since reset
   int          last_e;  // edge index just taken (-1 for a reset edge)

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  dpv;
      logic        blz;
      logic [27:0] eseg;  // expected seg level per digit {d3,d2,d1,d0}
      logic [3:0]  edp;   // expected dp level per digit {d3,d2,d1,d0}
   } vec_t;

   vec_t tv [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock edge: predict, advance model, then compare all outputs.
   task automatic step();
      logic [6:0] es;
      logic       ed;
      logic [3:0] ea;
      logic       ef;
      logic       blank;
      int         e;
      int         di;
      if (rst) begin
         es = 7'h7F; ed = 1'b1; ea = 4'b1110; ef = 1'b0;
         m_disp = 16'hFFFF; m_shad = 16'hFFFF;
         m_dp = 4'h0; m_sdp = 4'h0; m_pend = 1'b0;
         k = 0; last_e = -1;
      end else begin
         e  = k;
         di = (e % 16) / 4;
         blank = blank_lz && (di > 0) && ((m_disp >> (4 * di)) == 16'h0000);
         es = blank ? 7'h7F : ~SEG_TBL[(m_disp >> (4 * di)) & 16'h000F];
         ed = !(m_dp[di] && !blank);
         ea = ~(4'b0001 << di);
         ef = ((e % 16) == 0) && (e > 0);
         if ((e % 16) == 15) begin
            if (load) begin
               m_disp = bcd_in; m_dp = dp_in;
            end else if (m_pend) begin
               m_disp = m_shad; m_dp = m_sdp;
            end
            m_pend = 1'b0;
         end else if (load) begin
            m_shad = bcd_in; m_sdp = dp_in; m_pend = 1'b1;
         end
         k++;
         last_e = e;
      end
      @(posedge clk);
      #1;
      vec_cnt++;
      if ({seg, dp, an, frame_done} !== {es, ed, ea, ef}) begin
         mis_cnt++;
         $display("FAIL step e=%0d: seg/dp/an/fd got %h/%b/%b/%b expected %h/%b/%b/%b",
                  last_e, seg, dp, an, frame_done, es, ed, ea, ef);
      end
   endtask

   // Advance until the next edge to be taken has the given in-frame position.
   task automatic run_to(input int phase);
      for (int i = 0; i < 32; i++) begin
         if ((k % 16) == phase) break;
         step();
      end
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      load = 1'b1; bcd_in = v; dp_in = d;
      step();
      load = 1'b0;
   endtask

   initial begin
      logic [6:0] cap_seg [4];
      logic       cap_dp  [4];
      int         cnt;

      tv[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
      tv[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
      tv[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
      tv[3] = '{16'h9876, 4'b0101, 1'b0, {7'h10, 7'h00, 7'h78, 7'h02}, 4'b1010};
      tv[4] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
      tv[5] = '{16'hABCF, 4'b1111, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000};
      tv[6] = '{16'h0070, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1100};
      tv[7] = '{16'h0008, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b1111};

      rst = 1'b1; load = 1'b0; bcd_in = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0;
      k = 0; last_e = -1;
      for (int i = 0; i < 3; i++) step();
      check("reset_an", {28'h0, an}, {28'h0, 4'b1110});
      check("reset_seg", {25'h0, seg}, {25'h0, 7'h7F});
      rst = 1'b0;

      // First cycle after release, then frame_done must pulse 4 times in 64 cycles.
      step();
      check("release_an", {28'h0, an}, {28'h0, 4'b1110});
      check("release_fd", {31'h0, frame_done}, 32'h0);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (frame_done) cnt++;
      end
      check("fd_count_64", cnt, 4);

      // Table: load mid-frame, then capture every digit of the following frame.
      for (int i = 0; i < 8; i++) begin
         blank_lz = tv[i].blz;
         run_to(6);
         pulse_load(tv[i].bcd, tv[i].dpv);
         run_to(0);
         for (int j = 0; j < 16; j++) begin
            step();
            if ((last_e % 4) == 1) begin
               cap_seg[(last_e % 16) / 4] = seg;
               cap_dp[(last_e % 16) / 4]  = dp;
            end
         end
         for (int d = 0; d < 4; d++) begin
            check($sformatf("tbl%0d_seg_d%0d", i, d), {25'h0, cap_seg[d]},
                  {25'h0, tv[i].eseg[7*d +: 7]});
            check($sformatf("tbl%0d_dp_d%0d", i, d), {31'h0, cap_dp[d]},
                  {31'h0, tv[i].edp[d]});
         end
      end

      // Two loads in one frame: the first value must never reach the display.
      blank_lz = 1'b0;
      run_to(3);
      pulse_load(16'h1111, 4'h0);
      run_to(9);
      pulse_load(16'h9876, 4'h0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (seg == 7'h79) cnt++;
      end
      check("last_load_wins", cnt, 0);

      // Load coincident with the wrap goes straight to the display.
      run_to(3);
      pulse_load(16'h5555, 4'h0);
      run_to(15);
      pulse_load(16'h4321, 4'h0);
      step();
      check("coincident_d0", {25'h0, seg}, {25'h0, 7'h79});
      for (int i = 0; i < 16; i++) step();
      check("coincident_no_pend", {25'h0, seg}, {25'h0, 7'h79});

      // Reset with a load pending: nothing stale may appear afterwards.
      run_to(5);
      pulse_load(16'h2468, 4'hF);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (seg != 7'h7F || dp != 1'b1) cnt++;
      end
      check("reset_discards_pending", cnt, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         load     = ($urandom_range(0, 7) == 0);
         bcd_in   = 16'($urandom) & 16'($urandom);
         dp_in    = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
         step();
      end
      rst = 1'b0; load = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
